// File: rtl/phase_sequencer.sv
// Instruction phase generator (phases 0..7) with run/stop/step/halt control
// of the core, plus saturating cycle and retired-instruction debug counters.
module phase_sequencer #(
    parameter int CNT_W    = 16,
    parameter bit AUTO_RUN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt_req,
    input  logic             start,
    input  logic             step,
    input  logic             stop,
    output logic [2:0]       phase,
    output logic             running,
    output logic             halted,
    output logic             instr_done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    // state  | meaning
    // IDLE   | core stopped, phase held at 0, waiting for start/step
    // RUN    | free-running, phase advances every clk
    // STEP   | executing exactly one instruction, then back to IDLE
    // HALTED | controller requested halt at phase 4, phase held at 0
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_STEP   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    localparam logic [1:0]       S_RESET = AUTO_RUN ? S_RUN : S_IDLE;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0] state;
    logic [1:0] state_nx;
    logic [2:0] phase_nx;
    logic       stop_pend;
    logic       stop_pend_nx;
    logic       active;
    logic       halt_now;
    logic       wrap;
    logic       retire;

    assign active   = (state == S_RUN) || (state == S_STEP);
    assign halt_now = active && (phase == 3'd4) && halt_req;
    assign wrap     = active && (phase == 3'd7);
    assign retire   = halt_now || wrap;

    always_comb begin
        state_nx     = state;
        phase_nx     = phase;
        stop_pend_nx = stop_pend;
        case (state)
            S_IDLE, S_HALTED: begin
                phase_nx = 3'd0;
                if (start) begin
                    state_nx = S_RUN;
                end else if (step) begin
                    state_nx = S_STEP;
                end
            end
            S_RUN: begin
                if (halt_now) begin
                    state_nx     = S_HALTED;
                    phase_nx     = 3'd0;
                    stop_pend_nx = 1'b0;
                end else if (wrap) begin
                    phase_nx = 3'd0;
                    // a stop arriving in phase 7 still ends the current instruction
                    if (stop_pend || stop) begin
                        state_nx     = S_IDLE;
                        stop_pend_nx = 1'b0;
                    end
                end else begin
                    phase_nx = phase + 3'd1;
                    if (stop) begin
                        stop_pend_nx = 1'b1;
                    end
                end
            end
            S_STEP: begin
                if (halt_now) begin
                    state_nx = S_HALTED;
                    phase_nx = 3'd0;
                end else if (wrap) begin
                    state_nx = S_IDLE;
                    phase_nx = 3'd0;
                end else begin
                    phase_nx = phase + 3'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                phase_nx = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_RESET;
            phase      <= 3'd0;
            stop_pend  <= 1'b0;
            running    <= AUTO_RUN;
            halted     <= 1'b0;
            instr_done <= 1'b0;
            cycle_cnt  <= '0;
            instr_cnt  <= '0;
        end else begin
            state      <= state_nx;
            phase      <= phase_nx;
            stop_pend  <= stop_pend_nx;
            running    <= (state_nx == S_RUN) || (state_nx == S_STEP);
            halted     <= (state_nx == S_HALTED);
            instr_done <= retire;
            if (active && (cycle_cnt != CNT_MAX)) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (retire && (instr_cnt != CNT_MAX)) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

endmodule
